// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: frequency-sequencing controller feeding the tuning-word input of a DDS core.
// A host loads F0/F1/STEP/DWELL/MODE one byte at a time. The block then outputs a registered
// tuning word every clock: fixed at F0, an upward sawtooth sweep, or a triangle sweep.
//
// Optional feature: define DDS_SWEEP_SHADOW_EN to stage addr 0-6 writes in shadow registers.
// The shadows are copied to the active set by the addr-7 (MODE) write.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   wr_en        byte write strobe
//   wr_addr      register byte address (0/1 F0, 2/3 F1, 4/5 STEP, 6 DWELL, 7 MODE)
//   wr_data      write data byte
//   run          level, 1 = sweep enabled
//   tuning_w     registered tuning word
//   sweep_active high while in the sweep state
//   wrap         one-cycle pulse when a step reloads F0
module dds_sweep_ctrl #(
  parameter int unsigned TW      = 16,
  parameter int unsigned DWELL_W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [2:0]    wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          run,
  output logic [TW-1:0] tuning_w,
  output logic          sweep_active,
  output logic          wrap
);

  typedef enum logic {StIdle, StSweep} state_e;

  // Byte-written bank: the shadow set when shadowing is enabled, otherwise the active set.
  logic [TW-1:0]      bk_f0_q, bk_f0_d, bk_f1_q, bk_f1_d, bk_step_q, bk_step_d;
  logic [DWELL_W-1:0] bk_dwell_q, bk_dwell_d;
  logic [1:0]         mode_q, mode_d;
  logic [DWELL_W+7:0] wr_data_ext;

  // Active configuration used by the sweep engine.
  logic [TW-1:0]      f0, f1, step;
  logic [DWELL_W-1:0] dwell;

  function automatic logic [TW-1:0] set_lo(input logic [TW-1:0] cur, input logic [7:0] b);
    return {cur[TW-1:8], b};
  endfunction

  // Bits of the high byte above TW-1 are discarded.
  function automatic logic [TW-1:0] set_hi(input logic [TW-1:0] cur, input logic [7:0] b);
    return {b[TW-9:0], cur[7:0]};
  endfunction

  assign wr_data_ext = {{DWELL_W{1'b0}}, wr_data};

  always_comb begin
    bk_f0_d    = bk_f0_q;
    bk_f1_d    = bk_f1_q;
    bk_step_d  = bk_step_q;
    bk_dwell_d = bk_dwell_q;
    mode_d     = mode_q;
    if (wr_en) begin
      case (wr_addr)
        3'd0:    bk_f0_d    = set_lo(bk_f0_q, wr_data);
        3'd1:    bk_f0_d    = set_hi(bk_f0_q, wr_data);
        3'd2:    bk_f1_d    = set_lo(bk_f1_q, wr_data);
        3'd3:    bk_f1_d    = set_hi(bk_f1_q, wr_data);
        3'd4:    bk_step_d  = set_lo(bk_step_q, wr_data);
        3'd5:    bk_step_d  = set_hi(bk_step_q, wr_data);
        3'd6:    bk_dwell_d = wr_data_ext[DWELL_W-1:0];
        default: mode_d     = wr_data[1:0];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bk_f0_q    <= '0;
      bk_f1_q    <= '0;
      bk_step_q  <= '0;
      bk_dwell_q <= '0;
      mode_q     <= '0;
    end else begin
      bk_f0_q    <= bk_f0_d;
      bk_f1_q    <= bk_f1_d;
      bk_step_q  <= bk_step_d;
      bk_dwell_q <= bk_dwell_d;
      mode_q     <= mode_d;
    end
  end

`ifdef DDS_SWEEP_SHADOW_EN
  logic [TW-1:0]      act_f0_q, act_f1_q, act_step_q;
  logic [DWELL_W-1:0] act_dwell_q;

  // The MODE write commits the whole staged set in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_f0_q    <= '0;
      act_f1_q    <= '0;
      act_step_q  <= '0;
      act_dwell_q <= '0;
    end else if (wr_en && (wr_addr == 3'd7)) begin
      act_f0_q    <= bk_f0_q;
      act_f1_q    <= bk_f1_q;
      act_step_q  <= bk_step_q;
      act_dwell_q <= bk_dwell_q;
    end
  end

  assign f0    = act_f0_q;
  assign f1    = act_f1_q;
  assign step  = act_step_q;
  assign dwell = act_dwell_q;
`else
  assign f0    = bk_f0_q;
  assign f1    = bk_f1_q;
  assign step  = bk_step_q;
  assign dwell = bk_dwell_q;
`endif

  // Sweep engine
  state_e             state_q;
  logic               dir_down_q;
  logic [DWELL_W-1:0] dwell_cnt_q;
  logic               cfg_valid;
  logic [TW:0]        nxt_up, dn_floor;

  assign cfg_valid = run && ((mode_q == 2'b01) || (mode_q == 2'b10)) &&
                     (step != '0) && (f0 < f1);

  // One extra bit so the step arithmetic never wraps modulo 2^TW.
  assign nxt_up   = {1'b0, tuning_w} + {1'b0, step};
  assign dn_floor = {1'b0, f0} + {1'b0, step};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      tuning_w     <= '0;
      sweep_active <= 1'b0;
      wrap         <= 1'b0;
      dir_down_q   <= 1'b0;
      dwell_cnt_q  <= '0;
    end else begin
      wrap <= 1'b0;
      case (state_q)
        StIdle: begin
          tuning_w <= f0;
          if (cfg_valid) begin
            state_q      <= StSweep;
            sweep_active <= 1'b1;
            dwell_cnt_q  <= '0;
            dir_down_q   <= 1'b0;
          end
        end
        StSweep: begin
          if (!cfg_valid) begin
            state_q      <= StIdle;
            sweep_active <= 1'b0;
            tuning_w     <= f0;
          end else if (dwell_cnt_q != dwell) begin
            dwell_cnt_q <= dwell_cnt_q + DWELL_W'(1);
          end else begin
            dwell_cnt_q <= '0;
            if ((mode_q == 2'b10) && dir_down_q) begin
              if ({1'b0, tuning_w} < dn_floor) begin
                tuning_w   <= f0;
                dir_down_q <= 1'b0;
                wrap       <= 1'b1;
              end else begin
                tuning_w <= tuning_w - step;
              end
            end else if (mode_q == 2'b01) begin
              if (nxt_up > {1'b0, f1}) begin
                tuning_w <= f0;
                wrap     <= 1'b1;
              end else begin
                tuning_w <= nxt_up[TW-1:0];
              end
            end else begin
              if (nxt_up >= {1'b0, f1}) begin
                tuning_w   <= f1;
                dir_down_q <= 1'b1;
              end else begin
                tuning_w <= nxt_up[TW-1:0];
              end
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl: expected per-cycle outputs are queued as stimulus is
// applied and compared on the falling edge, one entry per clock.
module tb_dds_sweep_ctrl;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        run;
  logic [15:0] tuning_w;
  logic        sweep_active;
  logic        wrap;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] tw;
    logic        act;
    logic        wrp;
  } exp_t;

  exp_t sb_q[$];

  dds_sweep_ctrl #(
    .TW      (16),
    .DWELL_W (8)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .run          (run),
    .tuning_w     (tuning_w),
    .sweep_active (sweep_active),
    .wrap         (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge; the write lands on the following rising edge.
  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic push(input logic [15:0] tw, input logic act, input logic wrp);
    exp_t e;
    e.tw  = tw;
    e.act = act;
    e.wrp = wrp;
    sb_q.push_back(e);
  endtask

  // Compares one queued entry per falling edge, starting with the current one.
  task automatic drain(input string tag);
    exp_t e;
    int   n = 0;
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check($sformatf("%s[%0d].tw", tag, n), 32'(tuning_w), 32'(e.tw));
      check($sformatf("%s[%0d].act", tag, n), 32'(sweep_active), 32'(e.act));
      check($sformatf("%s[%0d].wrap", tag, n), 32'(wrap), 32'(e.wrp));
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    run     = 1'b0;
    repeat (2) @(negedge clk);
    check("reset.tw", 32'(tuning_w), 32'h0);
    check("reset.act", 32'(sweep_active), 32'h0);
    check("reset.wrap", 32'(wrap), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Fixed mode
    wr(3'd0, 8'h34); wr(3'd1, 8'h12); wr(3'd7, 8'h00);
    run = 1'b1;
    @(negedge clk);
    repeat (4) push(16'h1234, 1'b0, 1'b0);
    drain("fixed");

    // Sawtooth, DWELL=1: each value held two cycles
    run = 1'b0;
    wr(3'd0, 8'h00); wr(3'd1, 8'h01); wr(3'd2, 8'h30); wr(3'd3, 8'h01);
    wr(3'd4, 8'h10); wr(3'd5, 8'h00); wr(3'd6, 8'h01); wr(3'd7, 8'h01);
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    repeat (2) push(16'h0100, 1'b1, 1'b0);
    repeat (2) push(16'h0110, 1'b1, 1'b0);
    repeat (2) push(16'h0120, 1'b1, 1'b0);
    repeat (2) push(16'h0130, 1'b1, 1'b0);
    push(16'h0100, 1'b1, 1'b1);
    push(16'h0100, 1'b1, 1'b0);
    push(16'h0110, 1'b1, 1'b0);
    drain("saw");
    run = 1'b0;
    @(negedge clk);
    repeat (2) push(16'h0100, 1'b0, 1'b0);
    drain("saw_exit");

    // Triangle, DWELL=0
    wr(3'd0, 8'h10); wr(3'd1, 8'h00); wr(3'd2, 8'h38); wr(3'd3, 8'h00);
    wr(3'd4, 8'h10); wr(3'd6, 8'h00); wr(3'd7, 8'h02);
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    push(16'h0010, 1'b1, 1'b0);
    push(16'h0020, 1'b1, 1'b0);
    push(16'h0030, 1'b1, 1'b0);
    push(16'h0038, 1'b1, 1'b0);
    push(16'h0028, 1'b1, 1'b0);
    push(16'h0018, 1'b1, 1'b0);
    push(16'h0010, 1'b1, 1'b1);
    push(16'h0020, 1'b1, 1'b0);
    drain("tri");
    run = 1'b0;
    @(negedge clk);
    push(16'h0010, 1'b0, 1'b0);
    drain("tri_exit");

    // Invalid configurations keep the block idle at F0
    wr(3'd4, 8'h00);
    run = 1'b1;
    @(negedge clk);
    repeat (3) push(16'h0010, 1'b0, 1'b0);
    drain("step0");
    run = 1'b0;
    wr(3'd4, 8'h10); wr(3'd0, 8'h40);
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    repeat (3) push(16'h0040, 1'b0, 1'b0);
    drain("f0_gt_f1");
    wr(3'd0, 8'h38);
    @(negedge clk);
    repeat (3) push(16'h0038, 1'b0, 1'b0);
    drain("f0_eq_f1");

    // Asynchronous reset in the middle of a sweep
    wr(3'd0, 8'h10);
    repeat (3) @(negedge clk);
    check("pre_rst.act", 32'(sweep_active), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst.tw", 32'(tuning_w), 32'h0);
    check("async_rst.act", 32'(sweep_active), 32'h0);
    check("async_rst.wrap", 32'(wrap), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("post_rst.tw", 32'(tuning_w), 32'h0);
    check("post_rst.act", 32'(sweep_active), 32'h0);

`ifdef DDS_SWEEP_SHADOW_EN
    // Staged F1 has no effect until the MODE write commits it
    run = 1'b0;
    wr(3'd0, 8'h00); wr(3'd1, 8'h01); wr(3'd2, 8'h30); wr(3'd3, 8'h01);
    wr(3'd4, 8'h10); wr(3'd6, 8'h00); wr(3'd7, 8'h01);
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    push(16'h0100, 1'b1, 1'b0);
    push(16'h0110, 1'b1, 1'b0);
    drain("shadow_pre");
    wr(3'd2, 8'h20);
    push(16'h0130, 1'b1, 1'b0);
    push(16'h0100, 1'b1, 1'b1);
    push(16'h0110, 1'b1, 1'b0);
    push(16'h0120, 1'b1, 1'b0);
    push(16'h0130, 1'b1, 1'b0);
    drain("shadow_held");
    wr(3'd7, 8'h01);
    push(16'h0110, 1'b1, 1'b0);
    push(16'h0120, 1'b1, 1'b0);
    push(16'h0100, 1'b1, 1'b1);
    drain("shadow_commit");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
